sr_using_t_bank: RTL and testbench
==================================

SR_USING_T_BANK -- requirements
Module: sr_using_t_bank

Interface
REQ-001 Parameter WIDTH, default 8: number of SR cells in the bank.
REQ-002 Parameter CNT_W, default 8: width of the toggle and conflict counters.
REQ-003 Ports:
- clk, input, 1: the only clock; all state updates on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- en, input, 1: update enable; when low, all state holds.
- s, input, WIDTH: per-cell set request.
- r, input, WIDTH: per-cell reset request.
- clr_err, input, 1: clears the sticky error flag and conflict_cnt.
- q, output, WIDTH: stored cell values.
- known, output, WIDTH: per-cell validity; 1 means q[i] is defined.
- t_out, output, WIDTH: combinational T drive applied to each cell this cycle.
- toggle_cnt, output, CNT_W: count of enabled cycles with t_out nonzero.
- conflict_cnt, output, CNT_W: count of enabled cycles with any s[i]&r[i].
- err, output, 1: sticky conflict flag.
- state, output, 2: status FSM encoding.

Function
REQ-004 Storage SHALL be T flip-flops only: q[i] <= q[i] ^ t_out[i] when en=1; no direct load of q other than reset.
REQ-005 t_out[i] SHALL be (s[i] & ~q[i]) | (r[i] & q[i]), gated by en, so S=1 drives q to 1, R=1 drives q to 0, and S=R=0 holds.
REQ-006 The S/R-to-Q latency SHALL be one clock: a request sampled on edge n is visible on q after edge n.
REQ-007 Conflict (s[i]=r[i]=1, en=1), macro absent: t_out[i]=0, q[i] holds, known[i] <= 0.
REQ-008 known[i] SHALL return to 1 on the first enabled cycle with exactly one of s[i], r[i] high; q[i] then takes the requested value even if the prior q[i] was unknown.
REQ-009 known[i] SHALL be unaffected by hold cycles (s[i]=r[i]=0).
REQ-010 toggle_cnt SHALL increment by 1 per enabled cycle with |t_out, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-011 conflict_cnt SHALL increment by 1 per enabled cycle with any conflict bit, and SHALL saturate at 2^CNT_W-1.
REQ-012 err SHALL set on any enabled conflict cycle and remain set until clr_err or rst.
REQ-013 clr_err coincident with a conflict: the set wins; err=1 and conflict_cnt=1 after the edge.
REQ-014 Status FSM:
- CLEAN (2'b00): all known.
- DIRTY (2'b01): any known=0.
- RECOVER (2'b10): all known again while err=1.
REQ-015 FSM transitions, evaluated on next-state known and err:
- CLEAN->DIRTY on any unknown.
- DIRTY->RECOVER when all cells become known and err=1.
- DIRTY->CLEAN when all cells become known and err=0.
- RECOVER->CLEAN on clr_err.
- RECOVER->DIRTY on a new unknown.
REQ-016 With en=0, q, known, counters, err and the FSM SHALL hold; clr_err SHALL still act.

Reset
REQ-017 rst=1 at an edge SHALL force q=0, known=all 1s, toggle_cnt=0, conflict_cnt=0, err=0, state=CLEAN.
REQ-018 rst SHALL override en, s, r and clr_err in the same cycle, including mid-conflict or mid-recovery.
REQ-019 t_out SHALL read 0 while rst=1.

Configuration
REQ-020 Macro SR_SET_DOMINANT_EN:
- Defined: a conflict is treated as set. t_out[i] = ~q[i] & s[i], known stays 1, and conflict_cnt and err still count and flag.
- Undefined: the REQ-007/008 unknown-tracking behaviour applies.

Verification
REQ-021 rst, then en=1, s=8'h05, r=0 for 1 cycle -> q=8'h05, t_out=8'h05 during that cycle, toggle_cnt=1.
REQ-022 q=8'h05, en=1, s=r=0 for 3 cycles -> q=8'h05, t_out=0, toggle_cnt unchanged.
REQ-023 Macro undefined, q=8'h05, s=r=8'h01 -> q=8'h05, known=8'hFE, err=1, conflict_cnt=1, state=DIRTY. Then r=8'h01 only -> q=8'h04, known=8'hFF, state=RECOVER. Then clr_err -> state=CLEAN, conflict_cnt=0.
REQ-024 Macro defined, q=0, s=r=8'h80 -> q=8'h80, known=8'hFF, err=1, state=CLEAN.
REQ-025 CNT_W=8, conflict every cycle for 300 cycles -> conflict_cnt=255. Toggling cell 0 each cycle for 256 cycles -> toggle_cnt wraps to 0.
REQ-026 state=DIRTY, err=1, rst pulse with s=8'hFF -> q=0, known=8'hFF, err=0, state=CLEAN, t_out=0 during rst.

Source files
------------

// File: rtl/sr_using_t_bank.sv
// Bank of SR cells built from T flip-flops, with conflict tracking, counters and status FSM.
// Optional macro SR_SET_DOMINANT_EN: a simultaneous S and R acts as set instead of marking the cell unknown.
module sr_using_t_bank #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] known,
   output logic [WIDTH-1:0] t_out,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             err,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      CLEAN   = 2'b00,
      DIRTY   = 2'b01,
      RECOVER = 2'b10
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] known_q, known_d, known_upd;
   logic [CNT_W-1:0] tog_q, tog_d;
   logic [CNT_W-1:0] conf_q, conf_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] conflict_v, t_raw, t_d;
   logic             any_conf;
   logic             all_known_d;

   always_comb begin
      conflict_v = s & r;
`ifdef SR_SET_DOMINANT_EN
      // Conflict behaves as a set: R only acts where S is low.
      t_raw      = (s & ~q_q) | (r & ~s & q_q);
      known_upd  = known_q;
`else
      t_raw      = ((s & ~q_q) | (r & q_q)) & ~conflict_v;
      known_upd  = (known_q & ~conflict_v) | (s ^ r);
`endif
      t_d        = (en && !rst) ? t_raw : '0;
      q_d        = q_q ^ t_d;
      known_d    = en ? known_upd : known_q;
      any_conf   = en && (|conflict_v);

      tog_d = tog_q;
      if (en && (|t_d)) tog_d = tog_q + CNT_W'(1);

      // A conflict in the same cycle as clr_err wins and restarts the count at one.
      conf_d = conf_q;
      err_d  = err_q;
      if (any_conf) begin
         err_d  = 1'b1;
         conf_d = clr_err ? CNT_W'(1) : ((&conf_q) ? conf_q : conf_q + CNT_W'(1));
      end else if (clr_err) begin
         err_d  = 1'b0;
         conf_d = '0;
      end

      all_known_d = &known_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q     <= '0;
         known_q <= '1;
         tog_q   <= '0;
         conf_q  <= '0;
         err_q   <= 1'b0;
         state_q <= CLEAN;
      end else begin
         q_q     <= q_d;
         known_q <= known_d;
         tog_q   <= tog_d;
         conf_q  <= conf_d;
         err_q   <= err_d;
         unique case (state_q)
            CLEAN:   if (!all_known_d) state_q <= DIRTY;
            DIRTY:   if (all_known_d)  state_q <= err_d ? RECOVER : CLEAN;
            RECOVER: begin
               if (!all_known_d) state_q <= DIRTY;
               else if (!err_d)  state_q <= CLEAN;
            end
            default: state_q <= CLEAN;
         endcase
      end
   end

   assign q            = q_q;
   assign known        = known_q;
   assign t_out        = t_d;
   assign toggle_cnt   = tog_q;
   assign conflict_cnt = conf_q;
   assign err          = err_q;
   assign state        = state_q;

endmodule

// File: tb/tb_sr_using_t_bank.sv
// Randomized and directed bench for sr_using_t_bank, checked against a per-cell behavioural model.
module tb_sr_using_t_bank;

   localparam int W     = 8;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SR_SET_DOMINANT_EN
   localparam bit SETDOM = 1'b1;
`else
   localparam bit SETDOM = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [W-1:0] s = '0;
   logic [W-1:0] r = '0;
   logic         clr_err = 1'b0;
   logic [W-1:0] q, known, t_out;
   logic [CNT_W-1:0] toggle_cnt, conflict_cnt;
   logic         err;
   logic [1:0]   state;

   sr_using_t_bank #(.WIDTH(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q), .known(known), .t_out(t_out), .toggle_cnt(toggle_cnt),
      .conflict_cnt(conflict_cnt), .err(err), .state(state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: each cell's target value follows from the request it sees.
   logic [W-1:0] mq, mk;
   int           mtog, mconf, mstate;
   bit           merr, mvalid = 1'b0;

   function automatic logic [W-1:0] target(input logic [W-1:0] sv, rv, qv);
      logic [W-1:0] t;
      for (int i = 0; i < W; i++) begin
         if (sv[i] && rv[i]) t[i] = SETDOM ? 1'b1 : qv[i];
         else if (sv[i])     t[i] = 1'b1;
         else if (rv[i])     t[i] = 1'b0;
         else                t[i] = qv[i];
      end
      return t;
   endfunction

   always @(posedge clk) begin
      logic [W-1:0] nq, nk;
      bit conf;
      if (rst) begin
         mq = '0; mk = '1; mtog = 0; mconf = 0; merr = 0; mstate = 0; mvalid = 1'b1;
      end else if (mvalid) begin
         nq = mq; nk = mk;
         if (en) begin
            nq = target(s, r, mq);
            for (int i = 0; i < W; i++) begin
               if (s[i] && r[i]) begin
                  if (!SETDOM) nk[i] = 1'b0;
               end else if (s[i] || r[i]) nk[i] = 1'b1;
            end
         end
         conf = en && ((s & r) != '0);
         if (en && nq != mq) mtog = (mtog + 1) % (CMAX + 1);
         if (conf) begin
            merr = 1;
            mconf = clr_err ? 1 : ((mconf < CMAX) ? mconf + 1 : CMAX);
         end else if (clr_err) begin
            merr = 0; mconf = 0;
         end
         case (mstate)
            0: if (nk != '1) mstate = 1;
            1: if (nk == '1) mstate = merr ? 2 : 0;
            default: if (nk != '1) mstate = 1; else if (!merr) mstate = 0;
         endcase
         mq = nq; mk = nk;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("q", 32'(q), 32'(mq));
         chk("known", 32'(known), 32'(mk));
         chk("t_out", 32'(t_out), (rst || !en) ? 32'd0 : 32'(target(s, r, mq) ^ mq));
         chk("toggle_cnt", 32'(toggle_cnt), 32'(mtog));
         chk("conflict_cnt", 32'(conflict_cnt), 32'(mconf));
         chk("err", 32'(err), 32'(merr));
         chk("state", 32'(state), 32'(mstate));
      end
   end

   task automatic drive(input logic rst_v, en_v, input logic [W-1:0] s_v, r_v, input logic clr_v);
      rst = rst_v; en = en_v; s = s_v; r = r_v; clr_err = clr_v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 0, '0, '0, 0);
      tick(); tick();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_known", 32'(known), 32'hFF);
      chk("rst_state", 32'(state), 32'd0);

      drive(0, 1, 8'h05, 8'h00, 0);
      #1 chk("set05_t_out", 32'(t_out), 32'h05);
      tick();
      chk("set05_q", 32'(q), 32'h05);
      chk("set05_tog", 32'(toggle_cnt), 32'd1);

      drive(0, 1, '0, '0, 0);
      tick(); tick(); tick();
      chk("hold_q", 32'(q), 32'h05);
      chk("hold_t_out", 32'(t_out), 32'h00);
      chk("hold_tog", 32'(toggle_cnt), 32'd1);

`ifndef SR_SET_DOMINANT_EN
      drive(0, 1, 8'h01, 8'h01, 0);
      #1 chk("conf_t_out", 32'(t_out), 32'h00);
      tick();
      chk("conf_q", 32'(q), 32'h05);
      chk("conf_known", 32'(known), 32'hFE);
      chk("conf_err", 32'(err), 32'd1);
      chk("conf_cnt", 32'(conflict_cnt), 32'd1);
      chk("conf_state", 32'(state), 32'd1);

      drive(0, 1, 8'h00, 8'h01, 0);
      tick();
      chk("rec_q", 32'(q), 32'h04);
      chk("rec_known", 32'(known), 32'hFF);
      chk("rec_state", 32'(state), 32'd2);

      drive(0, 1, '0, '0, 1);
      tick();
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_cnt", 32'(conflict_cnt), 32'd0);

      drive(0, 1, 8'h02, 8'h02, 1);
      tick();
      chk("clrconf_err", 32'(err), 32'd1);
      chk("clrconf_cnt", 32'(conflict_cnt), 32'd1);

      drive(0, 0, 8'hFF, 8'h00, 1);
      #1 chk("dis_t_out", 32'(t_out), 32'h00);
      tick();
      chk("dis_q", 32'(q), 32'h04);
      chk("dis_known", 32'(known), 32'hFD);
      chk("dis_err", 32'(err), 32'd0);
      chk("dis_tog", 32'(toggle_cnt), 32'd2);
      chk("dis_state", 32'(state), 32'd1);

      drive(0, 1, 8'h04, 8'h04, 0);
      tick();
      drive(1, 1, 8'hFF, 8'h00, 0);
      #1 chk("rstmid_t_out", 32'(t_out), 32'h00);
      tick();
      chk("rstmid_q", 32'(q), 32'h00);
      chk("rstmid_known", 32'(known), 32'hFF);
      chk("rstmid_err", 32'(err), 32'd0);
      chk("rstmid_state", 32'(state), 32'd0);
`else
      drive(1, 0, '0, '0, 0);
      tick();
      drive(0, 1, 8'h80, 8'h80, 0);
      tick();
      chk("sd_q", 32'(q), 32'h80);
      chk("sd_known", 32'(known), 32'hFF);
      chk("sd_err", 32'(err), 32'd1);
      chk("sd_state", 32'(state), 32'd0);
`endif

      for (int k = 0; k < 300; k++) begin
         drive(0, 1, 8'h01, 8'h01, 0);
         tick();
      end
      chk("sat_cnt", 32'(conflict_cnt), 32'd255);

      drive(1, 0, '0, '0, 0);
      tick();
      for (int k = 0; k < 256; k++) begin
         drive(0, 1, (k % 2 == 0) ? 8'h01 : 8'h00, (k % 2 == 1) ? 8'h01 : 8'h00, 0);
         tick();
         if (k == 254) chk("tog_255", 32'(toggle_cnt), 32'd255);
      end
      chk("tog_wrap", 32'(toggle_cnt), 32'd0);

      for (int k = 0; k < 2000; k++) begin
         logic [W-1:0] sv, rv;
         sv = W'($urandom);
         rv = W'($urandom);
         if ($urandom_range(3) != 0) rv = rv & ~sv;
         drive(($urandom_range(99) == 0), ($urandom_range(7) != 0), sv, rv,
               ($urandom_range(9) == 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
